cla_serial_alu_seq: RTL
=======================

Name: cla_serial_alu_seq

Overview:
- Multi-cycle adder/subtractor/comparator built around one shared 4-bit carry-lookahead slice (cla_4bit), instantiated inside this block.
- Processes a WIDTH-bit operation one nibble per cycle, least-significant nibble first, with a registered carry between slices.
- Produces sum, carry-out, overflow and branch-compare flags (eq, lt, ltu).
- Sits in the BRC area as a low-area alternative to a full-width comparator/adder; driven by a start/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 8.
- NSLICE, WIDTH/4, number of nibble passes; derived, not overridable.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  request; sampled only when the FSM is in IDLE or DONE.
- i_a  in  WIDTH  operand A; latched when i_start is accepted.
- i_b  in  WIDTH  operand B; latched when i_start is accepted.
- i_sub  in  1  1 = A-B (B inverted, carry-in 1); 0 = A+B (carry-in 0).
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle pulse; results valid from this cycle.
- o_sum  out  WIDTH  result.
- o_cout  out  1  carry out of the MSB slice.
- o_ovf  out  1  signed overflow.
- o_eq  out  1  o_sum == 0.
- o_lt  out  1  signed less-than, meaningful when the op was a subtract.
- o_ltu  out  1  unsigned less-than, meaningful when the op was a subtract.

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - state = IDLE, nibble index = 0, carry register = 0.
  - Operand registers and all outputs = 0.
  - Reset has priority over every other event, including mid-RUN; no o_done is produced for an aborted op.
- FSM states: IDLE, RUN, DONE.
  - IDLE, i_start=1: latch A, latch B' (B' = i_sub ? ~i_b : i_b), carry = i_sub, idx = 0, clear o_sum, go to RUN.
  - RUN, each edge: feed A[4*idx+3:4*idx], B'[same] and carry to the slice; write S into o_sum nibble idx; carry <= Cout; idx++.
  - RUN, edge with idx = NSLICE-1: go to DONE and register the flags.
  - DONE: o_done = 1 for exactly this one cycle.
  - DONE, i_start=1: same action as from IDLE (back-to-back accepted, no idle bubble).
  - DONE, i_start=0: go to IDLE.
- i_start in RUN is ignored; latched operands do not change.
- Latency: accept edge E; o_done is high during the cycle after edge E+NSLICE (NSLICE+1 edges after E, including the accept edge). WIDTH=32 gives 9 cycles from accept to done.
- Throughput: one op per NSLICE+1 cycles.
- Output hold:
  - o_sum, o_cout, o_ovf, o_eq, o_lt and o_ltu hold their last result through IDLE until the next accept.
  - o_sum shows partial nibbles during RUN and is valid only from o_done.
- o_busy = (state == RUN). o_done = (state == DONE).
- Flags, registered on the final RUN edge from the full result:
  - o_cout = final slice Cout.
  - o_ovf = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]).
  - o_eq = ~|sum.
  - o_lt = sum[MSB] ^ o_ovf.
  - o_ltu = ~o_cout.
- Arithmetic: all arithmetic is modulo 2^WIDTH; there is no saturation.
- Index counter: width clog2(NSLICE); it never wraps past NSLICE-1 within an op.

Test Plan:
- Add with wrap: A=0x00000001, B=0xFFFFFFFF, sub=0 -> after done, o_sum=0x00000000, cout=1, eq=1, ovf=0; o_done exactly 9 cycles after the accept edge and 1 cycle wide.
- Negative difference: sub, A=5, B=7 -> o_sum=0xFFFFFFFE, cout=0, ltu=1, lt=1, eq=0, ovf=0.
- Signed overflow: sub, A=0x80000000, B=0x00000001 -> o_sum=0x7FFFFFFF, ovf=1, lt=1, ltu=0, cout=1.
- Start ignored while busy: accept A=0x10,B=0x20 add; pulse i_start with A=0xFFFF, B=0xFFFF at RUN cycle 3 -> o_sum=0x00000030 and only one o_done.
- Reset mid-RUN: assert i_rst_n=0 for one edge at RUN cycle 4 -> next cycle o_busy=0, all outputs 0, no o_done; a new op afterwards completes correctly.
- Back-to-back: i_start held high, op1 add 1+2 then op2 sub 9-9 -> o_sum=3 at the first done; RUN restarts directly from DONE; o_sum=0, eq=1 at the second done, 9 cycles later.

Source files
------------

// File: rtl/cla_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : cla_serial_alu_seq
// Purpose  : Nibble-serial add/sub/compare on one shared 4-bit CLA slice.
// Revision : 1.0 - initial release
// ============================================================================

module cla_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Fully expanded lookahead: every carry depends only on p/g and cin.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_s    = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

module cla_serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_eq,
    output logic             o_lt,
    output logic             o_ltu
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = $clog2(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_final_sum;
    logic             w_ovf;

    assign w_a_nib = r_a[4*r_idx +: 4];
    assign w_b_nib = r_b[4*r_idx +: 4];

    cla_4bit u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // Flags are taken on the last pass, when the top nibble is still on the slice.
    assign w_final_sum = {w_s, o_sum[WIDTH-5:0]};
    assign w_ovf       = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_s[3] != r_a[WIDTH-1]);

    assign o_busy = (r_state == S_RUN);
    assign o_done = (r_state == S_DONE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
            o_ovf   <= 1'b0;
            o_eq    <= 1'b0;
            o_lt    <= 1'b0;
            o_ltu   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub;
                        r_idx   <= '0;
                        o_sum   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    o_sum[4*r_idx +: 4] <= w_s;
                    r_carry             <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= S_DONE;
                        o_cout  <= w_cout;
                        o_ovf   <= w_ovf;
                        o_eq    <= ~|w_final_sum;
                        o_lt    <= w_s[3] ^ w_ovf;
                        o_ltu   <= ~w_cout;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
